// File: rtl/iter_muldiv_alu_if.sv
// Execute-stage bus for iter_muldiv_alu: instruction fields in, result and busy/stall out.
// An instruction is consumed at a rising edge when (valid_in & ~nop & ~stall); while stall is 1 the source must hold every field unchanged.
interface iter_muldiv_alu_if #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
);
    logic             valid_in;
    logic             nop;
    logic [1:0]       ALUOp;
    logic [5:0]       funct;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             stall;
    logic [1:0]       fsm_state;

    modport master (
        output valid_in, nop, ALUOp, funct, dataA, dataB, shamt,
        input  result, zero, busy, stall, fsm_state
    );

    modport slave (
        input  valid_in, nop, ALUOp, funct, dataA, dataB, shamt,
        output result, zero, busy, stall, fsm_state
    );
endinterface

// File: rtl/iter_muldiv_alu.sv
// MIPS EX-stage ALU: combinational ALU/shift results plus iterative MULTU/MADDU/DIVU into HI/LO.
// Multiply is one shift-add step per cycle, divide one restoring step per cycle, WIDTH steps each.
module iter_muldiv_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input logic clk,
    input logic reset,
    iter_muldiv_alu_if.slave bus
);
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_MADDU = 6'd28;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t             state;
    logic [SHW:0]       count;
    logic               busy_q;
    logic               maddu_q;
    logic [WIDTH-1:0]   hi, lo;
    logic [2*WIDTH-1:0] sh_a;     // multiplicand, shifted left each step
    logic [WIDTH-1:0]   sh_b;     // multiplier (MUL) or dividend/quotient (DIV)
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;

    logic eff, rtype, is_mul, is_div, is_mf, is_mt, needs_hilo;
    logic start, last;

    assign eff        = bus.valid_in & ~bus.nop;
    assign rtype      = (bus.ALUOp == 2'b10);
    assign is_mul     = rtype & ((bus.funct == F_MULTU) | (bus.funct == F_MADDU));
    assign is_div     = rtype & (bus.funct == F_DIVU);
    assign is_mf      = rtype & ((bus.funct == F_MFHI) | (bus.funct == F_MFLO));
    assign is_mt      = rtype & ((bus.funct == F_MTHI) | (bus.funct == F_MTLO));
    assign needs_hilo = is_mul | is_div | is_mf | is_mt;

    assign bus.stall     = eff & busy_q & needs_hilo;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;
    assign start         = eff & ~bus.stall & (is_mul | is_div);
    assign last          = (count == (SHW+1)'(1));

    // One iteration step of each algorithm; the final step's value goes straight to HI/LO.
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_nxt, div_quo_nxt;

    assign mul_acc_nxt = sh_b[0] ? acc + sh_a : acc;
    assign div_shift   = {rem, sh_b[WIDTH-1]};
    assign div_diff    = div_shift - {1'b0, divisor};
    assign div_ge      = ~div_diff[WIDTH];
    assign div_rem_nxt = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_nxt = {sh_b[WIDTH-2:0], div_ge};

    always_comb begin
        bus.result = '0;
        unique case (bus.ALUOp)
            2'b00: bus.result = bus.dataA + bus.dataB;
            2'b01: bus.result = bus.dataA - bus.dataB;
            2'b11: bus.result = bus.dataA | bus.dataB;
            default: begin
                case (bus.funct)
                    F_AND:   bus.result = bus.dataA & bus.dataB;
                    F_OR:    bus.result = bus.dataA | bus.dataB;
                    F_ADD:   bus.result = bus.dataA + bus.dataB;
                    F_SUB:   bus.result = bus.dataA - bus.dataB;
                    F_SLT:   bus.result = {{(WIDTH-1){1'b0}}, ($signed(bus.dataA) < $signed(bus.dataB))};
                    F_SRL:   bus.result = bus.dataA >> bus.shamt;
                    F_MFHI:  bus.result = hi;
                    F_MFLO:  bus.result = lo;
                    default: bus.result = '0;
                endcase
            end
        endcase
    end

    assign bus.zero = (bus.result == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy_q  <= 1'b0;
            maddu_q <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            sh_a    <= '0;
            sh_b    <= '0;
            divisor <= '0;
            acc     <= '0;
            rem     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count   <= (SHW+1)'(WIDTH);
                        busy_q  <= 1'b1;
                        acc     <= '0;
                        rem     <= '0;
                        maddu_q <= (bus.funct == F_MADDU);
                        if (is_mul) begin
                            state   <= MUL;
                            sh_a    <= {{WIDTH{1'b0}}, bus.dataA};
                            sh_b    <= bus.dataB;
                            divisor <= '0;
                        end else begin
                            state   <= DIV;
                            sh_a    <= '0;
                            sh_b    <= bus.dataA;
                            divisor <= bus.dataB;
                        end
                    end else if (eff & is_mt) begin
                        if (bus.funct == F_MTHI) hi <= bus.dataA;
                        else                     lo <= bus.dataA;
                    end
                end
                MUL: begin
                    acc   <= mul_acc_nxt;
                    sh_a  <= sh_a << 1;
                    sh_b  <= sh_b >> 1;
                    count <= count - 1'b1;
                    if (last) begin
                        {hi, lo} <= maddu_q ? {hi, lo} + mul_acc_nxt : mul_acc_nxt;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DIV: begin
                    rem   <= div_rem_nxt;
                    sh_b  <= div_quo_nxt;
                    count <= count - 1'b1;
                    if (last) begin
                        lo     <= div_quo_nxt;
                        hi     <= div_rem_nxt;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    count  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iter_muldiv_alu.sv
// Bench for iter_muldiv_alu: the same scenario suite is run against a WIDTH=32 and a WIDTH=16 instance.
// Expected values come from an arithmetic model of HI/LO and the ALU ops at the selected width.
module tb_iter_muldiv_alu;
    logic clk = 1'b0;
    logic reset;
    logic sel;   // 0 selects the 32-bit instance, 1 the 16-bit instance

    always #5 clk = ~clk;

    logic        d_valid, d_nop;
    logic [1:0]  d_aluop;
    logic [5:0]  d_funct;
    logic [31:0] d_a, d_b;
    logic [4:0]  d_sh;

    iter_muldiv_alu_if #(.WIDTH(32)) bus32();
    iter_muldiv_alu_if #(.WIDTH(16)) bus16();

    assign bus32.valid_in = d_valid & ~sel;
    assign bus32.nop      = d_nop;
    assign bus32.ALUOp    = d_aluop;
    assign bus32.funct    = d_funct;
    assign bus32.dataA    = d_a;
    assign bus32.dataB    = d_b;
    assign bus32.shamt    = d_sh;
    assign bus16.valid_in = d_valid & sel;
    assign bus16.nop      = d_nop;
    assign bus16.ALUOp    = d_aluop;
    assign bus16.funct    = d_funct;
    assign bus16.dataA    = d_a[15:0];
    assign bus16.dataB    = d_b[15:0];
    assign bus16.shamt    = d_sh[3:0];

    iter_muldiv_alu #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    iter_muldiv_alu #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

    logic [31:0] o_result;
    logic        o_zero, o_busy, o_stall;
    assign o_result = sel ? {16'h0, bus16.result} : bus32.result;
    assign o_zero   = sel ? bus16.zero  : bus32.zero;
    assign o_busy   = sel ? bus16.busy  : bus32.busy;
    assign o_stall  = sel ? bus16.stall : bus32.stall;

    int n_tests = 0;
    int n_fail  = 0;
    int w;
    logic [31:0] mask;
    logic [31:0] m_hi, m_lo;

    // ---------------- reference model ----------------
    function automatic logic is_decoded(input logic [5:0] fn);
        return fn inside {6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd2, 6'd25, 6'd28, 6'd27,
                          6'd16, 6'd18, 6'd17, 6'd19};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] fn,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh);
        logic signed [31:0] sa, sb;
        sa = (w == 32) ? a : {{16{a[15]}}, a[15:0]};
        sb = (w == 32) ? b : {{16{b[15]}}, b[15:0]};
        case (op)
            2'd0: return (a + b) & mask;
            2'd1: return (a - b) & mask;
            2'd3: return a | b;
            default: case (fn)
                6'd36: return a & b;
                6'd37: return a | b;
                6'd32: return (a + b) & mask;
                6'd34: return (a - b) & mask;
                6'd42: return (sa < sb) ? 32'd1 : 32'd0;
                6'd2:  return a >> sh;
                6'd16: return m_hi;
                6'd18: return m_lo;
                default: return 32'd0;
            endcase
        endcase
    endfunction

    task automatic apply_long(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, base;
        p    = 64'(a) * 64'(b);
        base = (64'(m_hi) << w) | 64'(m_lo);
        if (fn == 6'd28) p = p + base;
        if (w == 16) p = p & 64'hFFFF_FFFF;
        if (fn == 6'd27) begin
            if (b == 0) begin m_hi = a; m_lo = mask; end
            else begin m_lo = a / b; m_hi = a % b; end
        end else begin
            m_hi = 32'(p >> w) & mask;
            m_lo = p[31:0] & mask;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input logic nop_v);
        d_valid = 1'b1;
        d_nop   = nop_v;
        d_aluop = op;
        d_funct = fn;
        d_a     = a & mask;
        d_b     = b & mask;
        d_sh    = sh;
        #1;
    endtask

    task automatic idle_in();
        d_valid = 1'b0;
        d_nop   = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        tick();
        tick();
        reset = 1'b0;
        m_hi  = 0;
        m_lo  = 0;
    endtask

    task automatic start_long(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        drive(2'd2, fn, a, b, 5'd0, 1'b0);
        tick();
        apply_long(fn, a & mask, b & mask);
        idle_in();
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (o_busy === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        drive(2'd2, 6'd16, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tick();
        n_tests++;
        if (o_busy !== 1'b0 || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags w=%0d busy=%b stall=%b required 0 0", w, o_busy, o_stall);
        end
        n_tests++;
        if (o_result !== 32'd0 || o_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mfhi w=%0d result=%h zero=%b required 0 1", w, o_result, o_zero);
        end
        reset = 1'b0;
        drive(2'd2, 6'd18, 32'h0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if (o_result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mflo w=%0d result=%h required 0", w, o_result);
        end
        m_hi = 0;
        m_lo = 0;
        idle_in();
    endtask

    task automatic test_alu_directed();
        logic [1:0]  ops[4];
        logic [5:0]  fns[4];
        logic [31:0] as[4], bs[4], exps[4];
        logic [4:0]  shs[4];
        ops = '{2'd0, 2'd1, 2'd2, 2'd2};
        fns = '{6'd0, 6'd0, 6'd42, 6'd2};
        as  = '{mask >> 1, 32'd5, mask, 32'd1 << (w - 1)};
        bs  = '{32'd1, 32'd5, 32'd1, 32'd0};
        shs = '{5'd0, 5'd0, 5'd0, 5'(w - 1)};
        exps = '{32'd1 << (w - 1), 32'd0, 32'd1, 32'd1};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], fns[i], as[i], bs[i], shs[i], 1'b0);
            n_tests++;
            if (o_result !== exps[i] || o_zero !== (exps[i] == 0)) begin
                n_fail++;
                $display("FAIL alu_directed[%0d] w=%0d result=%h zero=%b required %h %b",
                         i, w, o_result, o_zero, exps[i], (exps[i] == 0));
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_alu_random();
        for (int i = 0; i < 60; i++) begin
            int k;
            logic [1:0]  op;
            logic [5:0]  fn;
            logic [31:0] a, b, exp;
            logic [4:0]  sh;
            k  = $urandom_range(0, 11);
            op = 2'd2;
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: op = 2'd0;
                1: op = 2'd1;
                2: op = 2'd3;
                3: fn = 6'd36;
                4: fn = 6'd37;
                5: fn = 6'd32;
                6: fn = 6'd34;
                7: fn = 6'd42;
                8: fn = 6'd2;
                9: while (is_decoded(fn)) fn = 6'($urandom_range(0, 63));
                10: fn = 6'd16;
                default: fn = 6'd18;
            endcase
            a  = ($urandom_range(0, 3) == 0) ? mask : ($urandom & mask);
            b  = ($urandom_range(0, 3) == 0) ? a : ($urandom & mask);
            sh = 5'($urandom_range(0, w - 1));
            exp = ref_alu(op, fn, a, b, sh);
            drive(op, fn, a, b, sh, 1'b0);
            n_tests++;
            if (o_result !== exp || o_zero !== (exp == 0) || o_stall !== 1'b0) begin
                n_fail++;
                $display("FAIL alu_random op=%0d fn=%0d w=%0d result=%h zero=%b stall=%b required %h %b 0",
                         op, fn, w, o_result, o_zero, o_stall, exp, (exp == 0));
            end
            tick();
        end
        idle_in();
    endtask

    task automatic check_hilo(input string name);
        drive(2'd2, 6'd16, 32'h0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if (o_result !== m_hi) begin
            n_fail++;
            $display("FAIL %s_hi w=%0d got=%h required %h", name, w, o_result, m_hi);
        end
        drive(2'd2, 6'd18, 32'h0, 32'h0, 5'd0, 1'b0);
        n_tests++;
        if (o_result !== m_lo) begin
            n_fail++;
            $display("FAIL %s_lo w=%0d got=%h required %h", name, w, o_result, m_lo);
        end
        idle_in();
    endtask

    task automatic test_multu();
        int c;
        start_long(6'd25, mask, mask);
        wait_idle(c);
        n_tests++;
        if (c != w) begin
            n_fail++;
            $display("FAIL multu_busy_cycles w=%0d got=%0d required %0d", w, c, w);
        end
        n_tests++;
        if (m_hi !== (mask - 1) || m_lo !== 32'd1) begin
            n_fail++;
            $display("FAIL multu_model w=%0d hi=%h lo=%h required %h 1", w, m_hi, m_lo, mask - 1);
        end
        check_hilo("multu_max");
        for (int i = 0; i < 4; i++) begin
            start_long(6'd25, $urandom, $urandom);
            wait_idle(c);
            check_hilo("multu_rand");
        end
    endtask

    task automatic test_maddu();
        int c;
        drive(2'd2, 6'd17, 32'd0, 32'd0, 5'd0, 1'b0);
        tick();
        m_hi = 0;
        drive(2'd2, 6'd19, 32'd5, 32'd0, 5'd0, 1'b0);
        tick();
        m_lo = 5;
        check_hilo("mt_then_mf");
        start_long(6'd28, 32'd3, 32'd4);
        wait_idle(c);
        n_tests++;
        if (m_lo !== 32'h11 || m_hi !== 32'd0) begin
            n_fail++;
            $display("FAIL maddu_model w=%0d hi=%h lo=%h required 0 11", w, m_hi, m_lo);
        end
        check_hilo("maddu_small");
        drive(2'd2, 6'd17, mask, 32'd0, 5'd0, 1'b0);
        tick();
        drive(2'd2, 6'd19, mask, 32'd0, 5'd0, 1'b0);
        tick();
        m_hi = mask;
        m_lo = mask;
        start_long(6'd28, 32'd1, 32'd1);
        wait_idle(c);
        check_hilo("maddu_wrap");
        for (int i = 0; i < 3; i++) begin
            start_long(6'd28, $urandom, $urandom);
            wait_idle(c);
            check_hilo("maddu_rand");
        end
    endtask

    task automatic test_divu();
        int c;
        start_long(6'd27, 32'd100, 32'd7);
        wait_idle(c);
        n_tests++;
        if (c != w || m_lo !== 32'd14 || m_hi !== 32'd2) begin
            n_fail++;
            $display("FAIL divu_100_7 w=%0d cycles=%0d model=%h/%h required %0d 2/14", w, c, m_hi, m_lo, w);
        end
        check_hilo("divu_100_7");
        start_long(6'd27, 32'd9, 32'd0);
        wait_idle(c);
        n_tests++;
        if (c != w) begin
            n_fail++;
            $display("FAIL divu_zero_cycles w=%0d got=%0d required %0d", w, c, w);
        end
        check_hilo("divu_by_zero");
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i < 2) ? 32'($urandom_range(1, 255)) : $urandom;
            start_long(6'd27, a, b);
            wait_idle(c);
            check_hilo("divu_rand");
        end
    endtask

    task automatic test_stall();
        int n, c;
        logic [31:0] a, b, exp;
        a = $urandom & mask;
        b = $urandom & mask;
        start_long(6'd25, a, b);
        tick();
        drive(2'd2, 6'd18, 32'd0, 32'd0, 5'd0, 1'b0);
        n = 0;
        while (o_stall === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != w - 1) begin
            n_fail++;
            $display("FAIL stall_cycles w=%0d got=%0d required %0d", w, n, w - 1);
        end
        n_tests++;
        if (o_result !== m_lo || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release_mflo w=%0d result=%h busy=%b required %h 0", w, o_result, o_busy, m_lo);
        end
        idle_in();
        start_long(6'd25, b, a);
        a = $urandom & mask;
        b = $urandom & mask;
        exp = (a + b) & mask;
        drive(2'd0, 6'd0, a, b, 5'd0, 1'b0);
        n_tests++;
        if (o_stall !== 1'b0 || o_busy !== 1'b1 || o_result !== exp) begin
            n_fail++;
            $display("FAIL add_during_busy w=%0d stall=%b busy=%b result=%h required 0 1 %h",
                     w, o_stall, o_busy, o_result, exp);
        end
        idle_in();
        wait_idle(c);
        check_hilo("after_add_busy");
    endtask

    task automatic test_back_to_back();
        int n, c;
        logic [31:0] a, b;
        start_long(6'd25, $urandom, $urandom);
        a = $urandom & mask;
        b = 32'($urandom_range(1, 1000));
        drive(2'd2, 6'd27, a, b, 5'd0, 1'b0);
        n = 0;
        while (o_stall === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        n_tests++;
        if (n != w) begin
            n_fail++;
            $display("FAIL b2b_hold_cycles w=%0d got=%0d required %0d", w, n, w);
        end
        tick();
        apply_long(6'd27, a, b);
        idle_in();
        wait_idle(c);
        n_tests++;
        if (c != w) begin
            n_fail++;
            $display("FAIL b2b_second_busy w=%0d got=%0d required %0d", w, c, w);
        end
        check_hilo("b2b_divu");
    endtask

    task automatic test_nop_during_busy();
        int c;
        start_long(6'd27, $urandom, $urandom);
        drive(2'd2, 6'd17, $urandom, 32'd0, 5'd0, 1'b1);
        n_tests++;
        if (o_stall !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_no_stall w=%0d stall=%b busy=%b required 0 1", w, o_stall, o_busy);
        end
        wait_idle(c);
        tick();
        n_tests++;
        if (c != w) begin
            n_fail++;
            $display("FAIL nop_busy_cycles w=%0d got=%0d required %0d", w, c, w);
        end
        idle_in();
        check_hilo("nop_busy");
    endtask

    task automatic test_reset_mid();
        int c;
        start_long(6'd27, $urandom, 32'($urandom_range(1, 50)));
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_busy w=%0d got=%b required 0", w, o_busy);
        end
        check_hilo("reset_mid");
        start_long(6'd25, 32'd2, 32'd3);
        wait_idle(c);
        n_tests++;
        if (m_lo !== 32'd6 || m_hi !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_model w=%0d hi=%h lo=%h required 0 6", w, m_hi, m_lo);
        end
        check_hilo("reset_mid_multu");
    endtask

    initial begin
        reset   = 1'b1;
        sel     = 1'b0;
        d_valid = 1'b0;
        d_nop   = 1'b0;
        d_aluop = 2'd0;
        d_funct = 6'd0;
        d_a     = 32'd0;
        d_b     = 32'd0;
        d_sh    = 5'd0;
        for (int s = 0; s < 2; s++) begin
            sel  = s[0];
            w    = (s == 0) ? 32 : 16;
            mask = (s == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
            do_reset();
            test_reset();
            test_alu_directed();
            test_alu_random();
            test_multu();
            test_maddu();
            test_divu();
            test_stall();
            test_back_to_back();
            test_nop_during_busy();
            test_reset_mid();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/iter_muldiv_alu.md
# iter_muldiv_alu

Parametrised execute-stage arithmetic unit for the MIPS pipeline. It computes single-cycle ALU and shift results combinationally, and runs iterative multi-cycle MULTU, MADDU and DIVU into internal HI/LO registers. A busy/stall handshake holds the pipeline only when an instruction depends on HI/LO while an iteration is in flight. Width is a parameter, and divide is supported.

## Interface
- WIDTH, 32, datapath width; must be ≥ 4 and a power of two
- SHW, log2(WIDTH), shamt width (derived; not overridden)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- valid_in  in  1  an instruction is present in EX this cycle
- nop  in  1  bubble; when 1, forces valid_in to be treated as 0
- ALUOp  in  2  00 ADD, 01 SUB, 10 decode funct, 11 OR
- funct  in  6  R-type function code, used when ALUOp = 10
- dataA  in  WIDTH  rs operand
- dataB  in  WIDTH  rt operand
- shamt  in  SHW  shift amount for SRL
- result  out  WIDTH  combinational result for the current instruction
- zero  out  1  result == 0
- busy  out  1  multi-cycle operation in flight
- stall  out  1  pipeline must hold EX; combinational

## Operation
- Decoded ops (funct, decimal): AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, MULTU 25, MADDU 28, DIVU 27, MFHI 16, MFLO 18, MTHI 17, MTLO 19. Any other funct gives result = 0 and no state change.
- ADD and SUB wrap modulo 2^WIDTH; no overflow trap.
- SLT is signed; result is 1 or 0, zero-extended.
- SRL is logical: dataA >> shamt.
- MFHI and MFLO drive result = HI / LO. MTHI and MTLO write dataA into HI / LO at the edge. These four are "HI/LO ops".
- For MULTU, MADDU, DIVU and MT*, result = 0. zero still follows result.
- Define eff = valid_in & ~nop.
- stall = eff & busy & (op is MULTU/MADDU/DIVU/MFHI/MFLO/MTHI/MTLO).
- Plain ALU and shift ops never stall, even while busy.
- Start: at an edge with eff & ~stall & op in {MULTU, MADDU, DIVU}:
  - latch operands and clear the accumulator
  - set count = WIDTH, busy = 1
- FSM states: IDLE, MUL, DIV.
  - IDLE→MUL on MULTU/MADDU start; IDLE→DIV on DIVU start.
  - MUL/DIV→IDLE at the edge where count goes 1→0.
- MUL: one shift-add step per cycle, unsigned, 2·WIDTH-bit product.
  - At completion, MULTU writes {HI,LO} = product.
  - MADDU writes {HI,LO} = {HI,LO}_at_start + product, modulo 2^(2·WIDTH).
- DIV: one restoring step per cycle, unsigned. At completion LO = quotient, HI = remainder.
- Divide by zero: runs the full WIDTH cycles, then HI = dividend, LO = all ones.
- HI/LO are written only at completion or by MT*; never partially.
- Reset at any time, including mid-iteration:
  - state IDLE, busy 0, count 0, HI = LO = 0, operand latches 0
  - the pending operation is discarded

## Timing
- Reset values: busy 0, stall 0. result and zero follow inputs combinationally, with HI = LO = 0.
- Single-cycle ops: result is valid in the same cycle as the inputs; latency 0.
- Multi-cycle: start accepted at edge E.
  - busy is 1 from after E through E+WIDTH, i.e. exactly WIDTH cycles.
  - HI/LO are updated at edge E+WIDTH, and busy falls at that same edge.
- Back-to-back: an MFHI in the cycle immediately after busy falls reads the new value.
  - An MFHI presented earlier sees stall = 1 and must be held by the pipeline with inputs unchanged.
  - A second MULTU/DIVU is likewise held and starts at the edge after busy falls.
- nop = 1 during busy does not affect the iteration.
- MTHI/MTLO with ~busy writes at its own edge; the next-cycle MFHI sees the new value.

## Test plan
- Reset then ADD 0x7FFFFFFF + 1 -> result 0x80000000, zero 0. SUB 5 − 5 -> result 0, zero 1. SLT 0xFFFFFFFF vs 1 -> 1. SRL 0x80000000 by 31 -> 1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - busy high exactly 32 cycles
  - then MFHI = 0xFFFFFFFE and MFLO = 0x00000001
- MTHI 0, MTLO 5, then MADDU 3 × 4 -> MFLO 0x11, MFHI 0. A MADDU with all-ones accumulator plus 1 × 1 -> HI = LO = 0.
- DIVU 100 / 7 -> LO 14, HI 2 after 32 busy cycles. DIVU 9 / 0 -> LO 0xFFFFFFFF, HI 9.
- Stall behaviour:
  - MULTU, then MFLO on the next cycle -> stall 1 for 31 cycles, then MFLO returns the product.
  - An ADD interleaved during busy -> stall 0 and a correct result.
- Reset asserted at cycle 10 of a DIVU -> busy 0 the next cycle, MFHI/MFLO = 0, and a fresh MULTU 2 × 3 yields LO 6. Repeat the full suite with WIDTH = 16.
